alu_pipe: RTL and testbench

Parametrised, two-stage pipelined successor to the generated single-cycle ALUs. It registers operands on a valid/ready handshake and computes all 16 opcodes, including the comparison ops SEQ/SLTU/SGT. It presents a registered result with carry, zero, negative and overflow flags. It sits between the operand-issue logic and the writeback stage, and stalls cleanly under downstream backpressure.

---
 rtl/alu_pipe.sv | 194 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined 16-opcode ALU with valid/ready handshakes.
//
// Stage 1 registers the opcode, operands and shift amount on an input handshake.
// Stage 2 registers the computed result and flags. Each stage has its own valid bit.
// Both stages advance whenever stage 2 is empty or downstream is taking the result.
//
// Ports:
//   clk, rst_n             rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready    operand beat handshake (in_ready is combinational on out_ready)
//   opcode, input1, input2 operation select and operands A / B
//   shiftValue             rotate/shift amount (naturally mod WIDTH)
//   out_valid / out_ready  result beat handshake
//   result                 registered result
//   carryFlag, zeroFlag, negFlag, ovfFlag  registered flags
//   stickyClr, stickyCarry only when ALU_STICKY_CARRY_EN is defined: stickyCarry
//                          accumulates carryFlag of retired beats; stickyClr clears it
//                          and takes priority over a same-cycle retire.
//
// Optional feature macro: ALU_STICKY_CARRY_EN
module alu_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [SHW-1:0]   shiftValue,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryFlag,
  output logic             zeroFlag,
  output logic             negFlag,
  output logic             ovfFlag
`ifdef ALU_STICKY_CARRY_EN
  ,
  input  logic             stickyClr,
  output logic             stickyCarry
`endif
);

  localparam logic [3:0] OpRol   = 4'd0;
  localparam logic [3:0] OpRor   = 4'd1;
  localparam logic [3:0] OpMax   = 4'd2;
  localparam logic [3:0] OpMin   = 4'd3;
  localparam logic [3:0] OpSub   = 4'd4;
  localparam logic [3:0] OpSeq   = 4'd5;
  localparam logic [3:0] OpXor   = 4'd6;
  localparam logic [3:0] OpSltu  = 4'd7;
  localparam logic [3:0] OpSgt   = 4'd8;
  localparam logic [3:0] OpXnor  = 4'd9;
  localparam logic [3:0] OpPassb = 4'd10;
  localparam logic [3:0] OpAdd   = 4'd11;
  localparam logic [3:0] OpAnd   = 4'd12;
  localparam logic [3:0] OpOr    = 4'd13;
  localparam logic [3:0] OpShl   = 4'd14;
  localparam logic [3:0] OpShr   = 4'd15;

  // Stage 1 state
  logic             s1_valid_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [SHW-1:0]   sh_q;

  // Stage 2 state
  logic             s2_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;

  // Next-state values computed from stage 1
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;

  logic             advance;
  logic             accept;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW:0]     inv_sh;

  assign advance  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || advance;
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum     = {1'b0, a_q} + {1'b0, b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    // For sh_q == 0 the complementary shift is by WIDTH, which yields zero.
    inv_sh  = (SHW + 1)'(WIDTH) - {1'b0, sh_q};
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    unique case (op_q)
      OpRol:   res_d = (a_q << sh_q) | (a_q >> inv_sh);
      OpRor:   res_d = (a_q >> sh_q) | (a_q << inv_sh);
      OpMax:   res_d = (a_q >= b_q) ? a_q : b_q;
      OpMin:   res_d = (a_q <= b_q) ? a_q : b_q;
      OpSub: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSeq:   res_d = {{(WIDTH-1){1'b0}}, (a_q == b_q)};
      OpXor:   res_d = a_q ^ b_q;
      OpSltu:  res_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
      OpSgt:   res_d = {{(WIDTH-1){1'b0}}, ($signed(a_q) > $signed(b_q))};
      OpXnor:  res_d = ~(a_q ^ b_q);
      OpPassb: res_d = b_q;
      OpAdd: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpAnd:   res_d = a_q & b_q;
      OpOr:    res_d = a_q | b_q;
      OpShl:   res_d = a_q << sh_q;
      OpShr:   res_d = a_q >> sh_q;
    endcase
  end

  // Stage 1: refills whenever it is empty or draining into stage 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sh_q       <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        op_q <= opcode;
        a_q  <= input1;
        b_q  <= input2;
        sh_q <= shiftValue;
      end
    end
  end

  // Stage 2: data only loads with a real beat so outputs hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else if (advance) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        res_q   <= res_d;
        carry_q <= carry_d;
        zero_q  <= (res_d == '0);
        neg_q   <= res_d[WIDTH-1];
        ovf_q   <= ovf_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = res_q;
  assign carryFlag = carry_q;
  assign zeroFlag  = zero_q;
  assign negFlag   = neg_q;
  assign ovfFlag   = ovf_q;

`ifdef ALU_STICKY_CARRY_EN
  logic sticky_q;

  // Clear wins over a same-cycle retire, dropping that beat's carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (stickyClr) begin
      sticky_q <= 1'b0;
    end else if (s2_valid_q && out_ready) begin
      sticky_q <= sticky_q | carry_q;
    end
  end

  assign stickyCarry = sticky_q;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH = 16).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_alu_pipe;

  localparam logic [3:0] OpAdd = 4'd11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] input1;
  logic [15:0] input2;
  logic [3:0]  shiftValue;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carryFlag;
  logic        zeroFlag;
  logic        negFlag;
  logic        ovfFlag;
`ifdef ALU_STICKY_CARRY_EN
  logic        stickyClr;
  logic        stickyCarry;
`endif

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic [15:0] res;
    logic [3:0]  flg;  // {carry, zero, neg, ovf}
  } vec_t;

  alu_pipe #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .input1     (input1),
    .input2     (input2),
    .shiftValue (shiftValue),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .carryFlag  (carryFlag),
    .zeroFlag   (zeroFlag),
    .negFlag    (negFlag),
    .ovfFlag    (ovfFlag)
`ifdef ALU_STICKY_CARRY_EN
    ,
    .stickyClr  (stickyClr),
    .stickyCarry(stickyCarry)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Drives one beat with out_ready high; returns out_valid one edge later and the
  // outputs two edges later.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] sh, output logic mid_valid, output logic [20:0] obs);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    opcode     = op;
    input1     = a;
    input2     = b;
    shiftValue = sh;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    mid_valid = out_valid;
    @(posedge clk);
    #1;
    obs = {out_valid, result, carryFlag, zeroFlag, negFlag, ovfFlag};
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    opcode     = '0;
    input1     = '0;
    input2     = '0;
    shiftValue = '0;
`ifdef ALU_STICKY_CARRY_EN
    stickyClr  = 1'b0;
`endif
    #2;
    checks++;
    if ({out_valid, in_ready, result, carryFlag, zeroFlag, negFlag, ovfFlag} !==
        {1'b0, 1'b1, 16'h0000, 4'b0000}) begin
      $display("FAIL reset_state: got valid=%b ready=%b result=%h flags=%b, required 0 1 0000 0000",
               out_valid, in_ready, result, {carryFlag, zeroFlag, negFlag, ovfFlag});
    end else passes++;
`ifdef ALU_STICKY_CARRY_EN
    checks++;
    if (stickyCarry !== 1'b0) begin
      $display("FAIL reset_sticky: got %b, required 0", stickyCarry);
    end else passes++;
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL post_reset_idle: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end else passes++;
  endtask

  task automatic test_ops;
    vec_t        vecs [23];
    logic        mid;
    logic [20:0] obs;
    vecs = '{
      '{4'd11, 16'hFFFF, 16'h0001, 4'd0,  16'h0000, 4'b1100},  // ADD wrap
      '{4'd4,  16'h8000, 16'h0001, 4'd0,  16'h7FFF, 4'b0001},  // SUB ovf
      '{4'd4,  16'h0001, 16'h0002, 4'd0,  16'hFFFF, 4'b1010},  // SUB borrow
      '{4'd8,  16'h0001, 16'hFFFF, 4'd0,  16'h0001, 4'b0000},  // SGT 1 > -1
      '{4'd7,  16'h0001, 16'hFFFF, 4'd0,  16'h0001, 4'b0000},  // SLTU
      '{4'd5,  16'h1234, 16'h1234, 4'd0,  16'h0001, 4'b0000},  // SEQ
      '{4'd0,  16'h8001, 16'h0000, 4'd1,  16'h0003, 4'b0000},  // ROL 1
      '{4'd1,  16'h8001, 16'h0000, 4'd15, 16'h0003, 4'b0000},  // ROR 15
      '{4'd2,  16'h1234, 16'h8000, 4'd0,  16'h8000, 4'b0010},  // MAX
      '{4'd3,  16'h1234, 16'h8000, 4'd0,  16'h1234, 4'b0000},  // MIN
      '{4'd6,  16'hF0F0, 16'hFF00, 4'd0,  16'h0FF0, 4'b0000},  // XOR
      '{4'd9,  16'hF0F0, 16'hFF00, 4'd0,  16'hF00F, 4'b0010},  // XNOR
      '{4'd10, 16'h0000, 16'hABCD, 4'd0,  16'hABCD, 4'b0010},  // PASSB
      '{4'd12, 16'hF0F0, 16'hFF00, 4'd0,  16'hF000, 4'b0010},  // AND
      '{4'd13, 16'hF0F0, 16'hFF00, 4'd0,  16'hFFF0, 4'b0010},  // OR
      '{4'd14, 16'h8001, 16'h0000, 4'd4,  16'h0010, 4'b0000},  // SHL 4
      '{4'd15, 16'h8001, 16'h0000, 4'd4,  16'h0800, 4'b0000},  // SHR 4
      '{4'd11, 16'h7FFF, 16'h0001, 4'd0,  16'h8000, 4'b0011},  // ADD ovf
      '{4'd8,  16'h8000, 16'h0001, 4'd0,  16'h0000, 4'b0100},  // SGT false
      '{4'd5,  16'h1234, 16'h1235, 4'd0,  16'h0000, 4'b0100},  // SEQ false
      '{4'd7,  16'hFFFF, 16'h0001, 4'd0,  16'h0000, 4'b0100},  // SLTU false
      '{4'd1,  16'h8001, 16'h0000, 4'd0,  16'h8001, 4'b0010},  // ROR 0
      '{4'd4,  16'h0005, 16'h0005, 4'd0,  16'h0000, 4'b0100}   // SUB zero
    };
    for (int i = 0; i < 23; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, mid, obs);
      checks++;
      if ({mid, obs} !== {1'b0, 1'b1, vecs[i].res, vecs[i].flg}) begin
        $display("FAIL op_vec[%0d] op=%0d: got mid_valid=%b valid=%b result=%h czno=%b, required 0 1 %h %b",
                 i, vecs[i].op, mid, obs[20], obs[19:4], obs[3:0], vecs[i].res, vecs[i].flg);
      end else passes++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_res [4];
    exp_res = '{16'h2020, 16'h3131, 16'h4242, 16'h5353};
    out_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      if (t < 4) begin
        in_valid = 1'b1;
        opcode   = OpAdd;
        input1   = 16'((t + 1) * 16'h1111);
        input2   = 16'h0F0F;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (t < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin
          $display("FAIL b2b_in_ready[%0d]: got %b, required 1", t, in_ready);
        end else passes++;
      end
      if (t >= 2 && t < 6) begin
        checks++;
        if ({out_valid, result} !== {1'b1, exp_res[t-2]}) begin
          $display("FAIL b2b_out[%0d]: got valid=%b result=%h, required 1 %h",
                   t - 2, out_valid, result, exp_res[t-2]);
        end else passes++;
      end else if (t == 6) begin
        checks++;
        if (out_valid !== 1'b0) begin
          $display("FAIL b2b_drain: got valid=%b, required 0", out_valid);
        end else passes++;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_backpressure;
    int   tx = 0;
    int   rx = 0;
    logic accepted;
    logic exp_rdy;
    for (int c = 0; c < 40 && rx < 8; c++) begin
      out_ready = (c >= 5);
      in_valid  = (tx < 8);
      opcode    = OpAdd;
      input1    = 16'(tx * 16'h0011);
      input2    = 16'h0100;
      #1;
      exp_rdy = (c >= 5) || (c < 2);
      checks++;
      if (in_ready !== exp_rdy) begin
        $display("FAIL bp_in_ready[c%0d]: got %b, required %b", c, in_ready, exp_rdy);
      end else passes++;
      if (c >= 2) begin
        checks++;
        if ({out_valid, result} !== {1'b1, 16'(16'h0100 + rx * 16'h0011)}) begin
          $display("FAIL bp_out[c%0d beat%0d]: got valid=%b result=%h, required 1 %h",
                   c, rx, out_valid, result, 16'(16'h0100 + rx * 16'h0011));
        end else passes++;
        if (out_ready) rx++;
      end
      accepted = in_valid && in_ready;
      @(posedge clk);
      if (accepted) tx++;
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if (rx != 8 || tx != 8) begin
      $display("FAIL bp_count: got sent=%0d retired=%0d within budget, required 8 8", tx, rx);
    end else passes++;
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_no_extra: got valid=%b after 8 beats, required 0", out_valid);
    end else passes++;
  endtask

  task automatic test_reset_midflight;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      opcode   = OpAdd;
      input1   = 16'(16'h0100 * (i + 1));
      input2   = 16'h0001;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      $display("FAIL mid_full: got valid=%b ready=%b, required 1 0", out_valid, in_ready);
    end else passes++;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      $display("FAIL mid_async_reset: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
    end else passes++;
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        $display("FAIL mid_after_release[%0d]: got valid=%b ready=%b, required 0 1",
                 i, out_valid, in_ready);
      end else passes++;
    end
  endtask

`ifdef ALU_STICKY_CARRY_EN
  task automatic test_sticky;
    logic        mid;
    logic [20:0] obs;
    stickyClr = 1'b1;
    @(posedge clk);
    #1;
    stickyClr = 1'b0;
    checks++;
    if (stickyCarry !== 1'b0) begin
      $display("FAIL sticky_cleared: got %b, required 0", stickyCarry);
    end else passes++;
    run_op(OpAdd, 16'hFFFF, 16'h0002, 4'd0, mid, obs);
    for (int i = 0; i < 3; i++) begin
      run_op(OpAdd, 16'h0001, 16'h0001, 4'd0, mid, obs);
      checks++;
      if (stickyCarry !== 1'b1) begin
        $display("FAIL sticky_hold[%0d]: got %b, required 1", i, stickyCarry);
      end else passes++;
    end
    run_op(OpAdd, 16'h8000, 16'h8000, 4'd0, mid, obs);
    stickyClr = 1'b1;
    @(posedge clk);
    #1;
    stickyClr = 1'b0;
    checks++;
    if (stickyCarry !== 1'b0) begin
      $display("FAIL sticky_clear_vs_retire: got %b, required 0", stickyCarry);
    end else passes++;
    @(posedge clk);
    #1;
    checks++;
    if (stickyCarry !== 1'b0) begin
      $display("FAIL sticky_stays_clear: got %b, required 0", stickyCarry);
    end else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
`ifdef ALU_STICKY_CARRY_EN
    test_sticky();
`endif
    test_reset_midflight();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
